// File: rtl/ge_fitness_driver.sv
//==============================================================================
// Module : ge_fitness_driver
// Drives a 2x2-multiplier individual with bit-parallel truth-table stimulus,
// captures its outputs and scores bits-correct against the target words.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module ge_fitness_driver #(
    parameter int unsigned SETTLE = 4,
    parameter logic [15:0] TGT_Y3 = 16'h8000,
    parameter logic [15:0] TGT_Y2 = 16'h4C00,
    parameter logic [15:0] TGT_Y1 = 16'h6AC0,
    parameter logic [15:0] TGT_Y0 = 16'hA0A0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic [15:0] a1,
    output logic [15:0] a0,
    output logic [15:0] b1,
    output logic [15:0] b0,
    input  logic [15:0] y3,
    input  logic [15:0] y2,
    input  logic [15:0] y1,
    input  logic [15:0] y0,
    output logic        busy,
    output logic        done,
    output logic [6:0]  score,
    output logic [3:0]  err_mask,
    output logic        perfect,
    output logic [15:0] eval_count
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_DRIVE   = 3'd1,
        S_CAPTURE = 3'd2,
        S_SCORE   = 3'd3,
        S_DONE    = 3'd4
    } state_t;

    localparam logic [7:0]       c_SETTLE_LOAD = 8'(SETTLE - 1);
    localparam logic [3:0][15:0] c_TGT         = {TGT_Y3, TGT_Y2, TGT_Y1, TGT_Y0};

    state_t           r_state;
    state_t           w_next;
    logic [7:0]       r_settle;
    logic [1:0]       r_word;
    logic [6:0]       r_acc;
    logic [3:0][15:0] r_cap;
    logic [15:0]      w_diff;
    logic [4:0]       w_hits;
    logic [6:0]       w_acc_next;
    logic             w_drive;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:    if (start) w_next = S_DRIVE;
            S_DRIVE:   if (r_settle == 8'd0) w_next = S_CAPTURE;
            S_CAPTURE: w_next = S_SCORE;
            S_SCORE:   if (r_word == 2'd3) w_next = S_DONE;
            S_DONE:    w_next = S_IDLE;
            default:   w_next = S_IDLE;
        endcase
    end

    // One captured word is scored per cycle, selected by r_word.
    always_comb begin
        w_diff     = r_cap[r_word] ^ c_TGT[r_word];
        w_hits     = 5'd16 - 5'($countones(w_diff));
        w_acc_next = r_acc + {2'b00, w_hits};
        w_drive    = (w_next == S_DRIVE) || (w_next == S_CAPTURE) || (w_next == S_SCORE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_settle   <= 8'd0;
            r_word     <= 2'd0;
            r_acc      <= 7'd0;
            r_cap      <= '0;
            a1         <= 16'h0000;
            a0         <= 16'h0000;
            b1         <= 16'h0000;
            b0         <= 16'h0000;
            busy       <= 1'b0;
            done       <= 1'b0;
            score      <= 7'd0;
            err_mask   <= 4'd0;
            perfect    <= 1'b0;
            eval_count <= 16'h0000;
        end else begin
            r_state <= w_next;
            busy    <= (w_next != S_IDLE);
            done    <= (w_next == S_DONE);
            a1      <= w_drive ? 16'hFF00 : 16'h0000;
            a0      <= w_drive ? 16'hF0F0 : 16'h0000;
            b1      <= w_drive ? 16'hCCCC : 16'h0000;
            b0      <= w_drive ? 16'hAAAA : 16'h0000;
            case (r_state)
                S_IDLE: begin
                    if (start) begin
                        score    <= 7'd0;
                        err_mask <= 4'd0;
                        perfect  <= 1'b0;
                        r_acc    <= 7'd0;
                        r_word   <= 2'd0;
                        r_settle <= c_SETTLE_LOAD;
                    end
                end
                S_DRIVE: begin
                    if (r_settle != 8'd0) r_settle <= r_settle - 8'd1;
                end
                S_CAPTURE: begin
                    r_cap <= {y3, y2, y1, y0};
                end
                S_SCORE: begin
                    r_acc            <= w_acc_next;
                    err_mask[r_word] <= err_mask[r_word] | (|w_diff);
                    r_word           <= r_word + 2'd1;
                    // Results land on the edge into DONE so they are valid with the pulse.
                    if (r_word == 2'd3) begin
                        score   <= w_acc_next;
                        perfect <= (w_acc_next == 7'd64);
                        if (eval_count != 16'hFFFF) eval_count <= eval_count + 16'd1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ge_fitness_driver.sv
//==============================================================================
// Module : tb_ge_fitness_driver
// Randomized self-checking bench for ge_fitness_driver with a lane-level model.
// Rev    : 1.0  initial release
//==============================================================================
`default_nettype none

module tb_ge_fitness_driver;

    localparam int SETTLE = 4;

    logic        clk;
    logic        rst_n;
    logic        start;
    logic [15:0] a1, a0, b1, b0;
    logic [15:0] y3, y2, y1, y0;
    logic        busy, done, perfect;
    logic [6:0]  score;
    logic [3:0]  err_mask;
    logic [15:0] eval_count;

    logic        zero_mode;
    logic [15:0] flip0, flip1, flip2, flip3;
    logic [3:0]  pl;
    logic [15:0] exp_cnt;

    int total = 0;
    int bad   = 0;

    ge_fitness_driver #(.SETTLE(SETTLE)) dut (
        .clk(clk), .rst_n(rst_n), .start(start),
        .a1(a1), .a0(a0), .b1(b1), .b0(b0),
        .y3(y3), .y2(y2), .y1(y1), .y0(y0),
        .busy(busy), .done(done), .score(score), .err_mask(err_mask),
        .perfect(perfect), .eval_count(eval_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [3:0] lane_prod(input logic [1:0] x, input logic [1:0] y);
        return {2'b00, x} * {2'b00, y};
    endfunction

    // Individual under test: per-lane multiplier with optional bit corruption.
    always_comb begin
        pl = '0;
        y3 = '0; y2 = '0; y1 = '0; y0 = '0;
        for (int i = 0; i < 16; i++) begin
            pl    = lane_prod({a1[i], a0[i]}, {b1[i], b0[i]});
            y0[i] = pl[0] ^ flip0[i];
            y1[i] = pl[1] ^ flip1[i];
            y2[i] = pl[2] ^ flip2[i];
            y3[i] = pl[3] ^ flip3[i];
        end
        if (zero_mode) begin
            y3 = '0; y2 = '0; y1 = '0; y0 = '0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Reference: lane i is a=i/4, b=i%4; the ideal response bit k is bit k of a*b.
    task automatic model(input logic zm, input logic [15:0] f0, input logic [15:0] f1,
                         input logic [15:0] f2, input logic [15:0] f3,
                         output int sc, output logic [3:0] em);
        logic [15:0] f;
        int prod, rb, cb;
        sc = 0;
        em = 4'b0000;
        for (int k = 0; k < 4; k++) begin
            f = (k == 0) ? f0 : (k == 1) ? f1 : (k == 2) ? f2 : f3;
            for (int i = 0; i < 16; i++) begin
                prod = (i / 4) * (i % 4);
                rb   = (prod >> k) & 1;
                cb   = zm ? 0 : (rb ^ int'(f[i]));
                if (cb == rb) sc++;
                else em[k] = 1'b1;
            end
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && !busy) chk("idle_stim", {a1 | a0 | b1 | b0}, 32'd0);
    end

    task automatic run_eval(input logic zm, input logic [15:0] f0, input logic [15:0] f1,
                            input logic [15:0] f2, input logic [15:0] f3,
                            input logic junk, input logic poke);
        int sc, lat, extra;
        logic [3:0] em;
        zero_mode = zm;
        flip0 = f0; flip1 = f1; flip2 = f2; flip3 = f3;
        model(zm, f0, f1, f2, f3, sc, em);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        lat = 1;
        chk("stim_a1", a1, 32'hFF00);
        chk("stim_b0", b0, 32'hAAAA);
        chk("busy_run", busy, 32'd1);
        while (!done && lat < 40) begin
            @(negedge clk);
            lat++;
            start = (poke && lat == SETTLE + 3);
            if (junk && lat == SETTLE + 2) begin
                flip0 = 16'($urandom); flip1 = 16'($urandom);
                flip2 = 16'($urandom); flip3 = 16'($urandom);
            end
        end
        start = 1'b0;
        exp_cnt = (exp_cnt == 16'hFFFF) ? 16'hFFFF : exp_cnt + 16'd1;
        chk("latency", lat, SETTLE + 6);
        chk("score", score, sc);
        chk("err_mask", err_mask, em);
        chk("perfect", perfect, (sc == 64));
        chk("eval_count", eval_count, exp_cnt);
        chk("stim_done", {a1 | a0 | b1 | b0}, 32'd0);
        @(negedge clk);
        chk("done_width", done, 32'd0);
        chk("score_hold", score, sc);
        if (poke) begin
            extra = 0;
            for (int c = 0; c < SETTLE + 8; c++) begin
                @(negedge clk);
                if (done) extra++;
            end
            chk("single_done", extra, 32'd0);
        end
        flip0 = '0; flip1 = '0; flip2 = '0; flip3 = '0;
        zero_mode = 1'b0;
    endtask

    initial begin
        int lat, ndone;
        rst_n = 1'b0; start = 1'b0; zero_mode = 1'b0;
        flip0 = '0; flip1 = '0; flip2 = '0; flip3 = '0;
        exp_cnt = 16'h0000;
        repeat (2) @(negedge clk);
        chk("rst_busy", busy, 32'd0);
        chk("rst_done", done, 32'd0);
        chk("rst_score", {perfect, err_mask, score}, 32'd0);
        chk("rst_count", eval_count, 32'd0);
        chk("rst_stim", {a1 | a0 | b1 | b0}, 32'd0);
        rst_n = 1'b1;

        run_eval(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_eval(1'b1, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        run_eval(1'b0, 16'h0000, 16'h0000, 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        run_eval(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b1, 1'b1);
        for (int r = 0; r < 10; r++) begin
            run_eval(1'b0,
                     $urandom_range(0, 1) ? 16'($urandom) : 16'h0000,
                     $urandom_range(0, 1) ? 16'($urandom) : 16'h0000,
                     $urandom_range(0, 1) ? 16'(1 << $urandom_range(0, 15)) : 16'h0000,
                     $urandom_range(0, 1) ? 16'($urandom) : 16'h0000,
                     1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        // Start held high: done pulses repeat every SETTLE+7 cycles.
        @(negedge clk);
        start = 1'b1;
        lat = 0;
        while (!done && lat < 40) begin @(negedge clk); lat++; end
        for (int p = 0; p < 2; p++) begin
            lat = 0;
            @(negedge clk);
            lat++;
            while (!done && lat < 40) begin @(negedge clk); lat++; end
            chk("b2b_period", lat, SETTLE + 7);
            chk("b2b_score", score, 32'd64);
        end
        start = 1'b0;
        exp_cnt = exp_cnt + 16'd3;
        chk("b2b_count", eval_count, exp_cnt);
        repeat (2) @(negedge clk);
        chk("b2b_idle", busy, 32'd0);

        // Asynchronous reset in the middle of SCORE.
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (SETTLE + 2) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("arst_busy", busy, 32'd0);
        chk("arst_stim", {a1 | a0 | b1 | b0}, 32'd0);
        chk("arst_count", eval_count, 32'd0);
        chk("arst_score", {perfect, err_mask, score}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        exp_cnt = 16'h0000;
        ndone = 0;
        for (int c = 0; c < 15; c++) begin
            @(negedge clk);
            if (done) ndone++;
        end
        chk("arst_no_done", ndone, 32'd0);
        chk("arst_count2", eval_count, 32'd0);
        run_eval(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);

        // Saturation of the evaluation counter.
        @(negedge clk);
        force dut.eval_count = 16'hFFFE;
        @(negedge clk);
        release dut.eval_count;
        exp_cnt = 16'hFFFE;
        @(negedge clk);
        chk("sat_preload", eval_count, 32'hFFFE);
        for (int s = 0; s < 3; s++) begin
            run_eval(1'b0, 16'h0000, 16'h0000, 16'h0000, 16'h0000, 1'b0, 1'b0);
        end
        chk("sat_final", eval_count, 32'hFFFF);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
